// File: rtl/pc_fetch_pkg.sv
// Shared types, widths and helpers for the instruction-fetch stage.
package pc_fetch_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned TCNT_W = 8;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        ISSUE  = 2'd1,
        HALTED = 2'd2,
        ERROR  = 2'd3
    } state_t;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_J     = 6'b000010;

    // Sign-extend a 16-bit immediate to the datapath width.
    function automatic logic [XLEN-1:0] sign_extend16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory read channel: req/addr from fetch, rdata/ready from memory.
interface pc_fetch_unit_if;

    logic                           imem_req;
    logic [pc_fetch_pkg::XLEN-1:0]  imem_addr;
    logic [pc_fetch_pkg::XLEN-1:0]  imem_rdata;
    logic                           imem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ready
    );

endinterface

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jump, taken beq, or sequential.
module next_pc_calc
    import pc_fetch_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] instruction,
    input  logic            branch_select,
    input  logic            jump_select,
    input  logic            alu_zero,
    output logic [XLEN-1:0] next_pc,
    output logic [XLEN-1:0] pc_plus4
);

    logic unused_opcode;

    assign unused_opcode = ^instruction[31:26];
    assign pc_plus4      = pc + 32'd4;

    // Jump beats branch; everything wraps at 32 bits.
    always_comb begin
        next_pc = pc_plus4;
        if (jump_select) begin
            next_pc = {pc_plus4[31:28], instruction[25:0], 2'b00};
        end else if (branch_select && alu_zero) begin
            next_pc = pc_plus4 + (sign_extend16(instruction[15:0]) << 2);
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: PC register, imem handshake, issue pulse, halt and timeout handling.
module pc_fetch_unit
    import pc_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned     TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    pc_fetch_unit_if.master  imem,
    input  logic             branch_select,
    input  logic             jump_select,
    input  logic             alu_zero,
    input  logic             halt_req,
    output logic [XLEN-1:0]  instruction,
    output logic             instr_valid,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_plus4,
    output logic             halted,
    output logic             fetch_error,
    output logic [XLEN-1:0]  instr_count
);

    localparam logic [TCNT_W-1:0] TMO_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state;
    state_t            next_state;
    logic [TCNT_W-1:0] tmo_cnt;
    logic [TCNT_W-1:0] tmo_cnt_next;
    logic              capture;
    logic              imem_req_q;
    logic [XLEN-1:0]   next_pc;

    assign imem.imem_req  = imem_req_q;
    assign imem.imem_addr = pc;

    next_pc_calc u_next_pc (
        .pc            (pc),
        .instruction   (instruction),
        .branch_select (branch_select),
        .jump_select   (jump_select),
        .alu_zero      (alu_zero),
        .next_pc       (next_pc),
        .pc_plus4      (pc_plus4)
    );

    // Next-state, timeout and capture decisions.
    always_comb begin
        next_state   = state;
        tmo_cnt_next = tmo_cnt;
        capture      = 1'b0;
        case (state)
            FETCH: begin
                // The request is only live once imem_req is actually driven high.
                if (imem_req_q) begin
                    if (imem.imem_ready) begin
                        capture      = 1'b1;
                        tmo_cnt_next = '0;
                        next_state   = ISSUE;
                    end else begin
                        tmo_cnt_next = tmo_cnt + TCNT_W'(1);
                        if (tmo_cnt == TMO_LAST) begin
                            next_state = ERROR;
                        end
                    end
                end
            end
            ISSUE:   next_state = halt_req ? HALTED : FETCH;
            HALTED:  if (!halt_req) next_state = FETCH;
            ERROR:   next_state = ERROR;
            default: next_state = FETCH;
        endcase
    end

    // State register plus registered per-state strobes (all low in reset).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            tmo_cnt     <= '0;
            imem_req_q  <= 1'b0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            fetch_error <= 1'b0;
        end else begin
            state       <= next_state;
            tmo_cnt     <= tmo_cnt_next;
            imem_req_q  <= (next_state == FETCH);
            instr_valid <= (next_state == ISSUE);
            halted      <= (next_state == HALTED);
            fetch_error <= (next_state == ERROR);
        end
    end

    // Datapath: instruction latch, PC update and issue counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            instruction <= '0;
            instr_count <= '0;
        end else begin
            if (capture) begin
                instruction <= imem.imem_rdata;
            end
            if (state == ISSUE) begin
                pc          <= next_pc;
                instr_count <= instr_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus randomized fetch stream vs. a reference model.
module tb_pc_fetch_unit;
    import pc_fetch_pkg::*;

    localparam int unsigned TMO = 16;

    logic        clk;
    logic        rst_n;
    logic        branch_select, jump_select, alu_zero, halt_req;
    logic [31:0] instruction, pc, pc_plus4, instr_count;
    logic        instr_valid, halted, fetch_error;

    pc_fetch_unit_if imem ();

    pc_fetch_unit #(.RESET_PC(32'h0), .TIMEOUT_CYCLES(TMO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem          (imem),
        .branch_select (branch_select),
        .jump_select   (jump_select),
        .alu_zero      (alu_zero),
        .halt_req      (halt_req),
        .instruction   (instruction),
        .instr_valid   (instr_valid),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .halted        (halted),
        .fetch_error   (fetch_error),
        .instr_count   (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    logic [31:0] m_pc;
    logic [31:0] m_count;

    // observations from the last step_instr call
    int          obs_req_cycles, obs_early_valid;
    bit          obs_addr_ok, obs_halt_ok;
    logic        obs_valid, obs_valid_after, obs_halted, obs_req_after;
    logic [31:0] obs_instr, obs_plus4, obs_pc_issue, obs_pc_after, obs_count_after;
    logic [31:0] exp_plus4;

    // Architectural next-PC rule, written with plain arithmetic.
    function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] w,
                                             input logic br, input logic jmp, input logic zero);
        logic [31:0] seq;
        int signed   off;
        seq = p + 32'd4;
        if (jmp) return (seq & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 32'd4);
        if (br && zero) begin
            off = int'($signed(w[15:0]));
            return seq + 32'(off * 4);
        end
        return seq;
    endfunction

    // One fetch (with `waits` stall cycles), its ISSUE cycle, and an optional halt period.
    task automatic step_instr(input int waits, input logic [31:0] word, input logic br,
                              input logic jmp, input logic zero, input int halt_cycles);
        int guard;
        guard = 0;
        obs_req_cycles = 0; obs_early_valid = 0; obs_addr_ok = 1; obs_halt_ok = 1;
        while (!imem.imem_req && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        if (!imem.imem_req) begin
            obs_valid = 1'b0; obs_pc_after = 'x; obs_instr = 'x; obs_count_after = 'x;
            return;
        end
        for (int w = 0; w <= waits; w++) begin
            if (imem.imem_req) obs_req_cycles++;
            if (imem.imem_addr !== m_pc) obs_addr_ok = 0;
            if (instr_valid) obs_early_valid++;
            imem.imem_ready = (w == waits);
            imem.imem_rdata = (w == waits) ? word : $urandom();
            halt_req      = 1'($urandom_range(0, 1));
            branch_select = 1'($urandom_range(0, 1));
            jump_select   = 1'($urandom_range(0, 1));
            alu_zero      = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        imem.imem_ready = 1'($urandom_range(0, 1));
        imem.imem_rdata = $urandom();
        branch_select = br; jump_select = jmp; alu_zero = zero;
        halt_req = (halt_cycles > 0);
        obs_valid = instr_valid; obs_instr = instruction; obs_plus4 = pc_plus4; obs_pc_issue = pc;
        exp_plus4 = m_pc + 32'd4;
        m_pc      = ref_next(m_pc, word, br, jmp, zero);
        m_count   = m_count + 32'd1;
        @(negedge clk);
        obs_halted = halted; obs_req_after = imem.imem_req; obs_valid_after = instr_valid;
        obs_pc_after = pc; obs_count_after = instr_count;
        imem.imem_ready = 1'b0;
        for (int h = 1; h < halt_cycles; h++) begin
            imem.imem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (!halted || imem.imem_req || pc !== obs_pc_after) obs_halt_ok = 0;
        end
        if (halt_cycles > 0) begin
            halt_req = 1'b0;
            imem.imem_ready = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic goto_addr(input logic [31:0] target);
        step_instr(0, {OPC_J, 26'(target >> 2)}, 1'b0, 1'b1, 1'b0, 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if ({imem.imem_req, instr_valid, halted, fetch_error} !== 4'b0 || pc !== 32'h0 ||
            instruction !== 32'h0 || instr_count !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_state: req/valid/halt/err=%b pc=%h instr=%h cnt=%0d exp all zero",
                     {imem.imem_req, instr_valid, halted, fetch_error}, pc, instruction, instr_count);
        end
        rst_n = 1'b1;
        m_pc = 32'h0; m_count = 32'h0;
        @(negedge clk);
        vectors++;
        if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_first_req: req=%b addr=%h exp req=1 addr=0", imem.imem_req, imem.imem_addr);
        end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            step_instr(0, {OPC_RTYPE, 26'($urandom())}, 1'b0, 1'b0, 1'b0, 0);
            vectors++;
            if (obs_pc_issue !== 32'(i * 4) || obs_req_cycles != 1 || obs_valid !== 1'b1 ||
                obs_valid_after !== 1'b0) begin
                miscompares++;
                $display("FAIL seq_fetch%0d: pc=%h reqcyc=%0d valid=%b/%b exp pc=%h 1 1/0",
                         i, obs_pc_issue, obs_req_cycles, obs_valid, obs_valid_after, 32'(i * 4));
            end
        end
        vectors++;
        if (instr_count !== 32'd3) begin
            miscompares++;
            $display("FAIL seq_count: got %0d exp 3", instr_count);
        end
    endtask

    task automatic test_branch();
        step_instr(0, {OPC_RTYPE, 26'h0}, 1'b0, 1'b0, 1'b0, 0);
        step_instr(0, {OPC_BEQ, 5'd1, 5'd2, 16'hFFFC}, 1'b1, 1'b0, 1'b1, 0);
        vectors++;
        if (obs_pc_issue !== 32'h10 || obs_pc_after !== 32'h4 || imem.imem_addr !== 32'h4) begin
            miscompares++;
            $display("FAIL beq_taken: at %h next %h addr %h exp 10 -> 4", obs_pc_issue, obs_pc_after, imem.imem_addr);
        end
        goto_addr(32'h10);
        step_instr(0, {OPC_BEQ, 5'd1, 5'd2, 16'hFFFC}, 1'b1, 1'b0, 1'b0, 0);
        vectors++;
        if (obs_pc_issue !== 32'h10 || obs_pc_after !== 32'h14) begin
            miscompares++;
            $display("FAIL beq_not_taken: at %h next %h exp 10 -> 14", obs_pc_issue, obs_pc_after);
        end
    endtask

    task automatic test_jump();
        goto_addr(32'h20);
        step_instr(0, {OPC_J, 26'h40}, 1'b0, 1'b1, 1'b0, 0);
        vectors++;
        if (obs_pc_issue !== 32'h20 || obs_pc_after !== 32'h100) begin
            miscompares++;
            $display("FAIL jump: at %h next %h exp 20 -> 100", obs_pc_issue, obs_pc_after);
        end
        goto_addr(32'h20);
        step_instr(0, {OPC_J, 26'h40}, 1'b1, 1'b1, 1'b1, 0);
        vectors++;
        if (obs_pc_after !== 32'h100) begin
            miscompares++;
            $display("FAIL jump_priority: next %h exp 100", obs_pc_after);
        end
    endtask

    task automatic test_wait();
        logic [31:0] word;
        word = {OPC_LW, 26'($urandom())};
        step_instr(3, word, 1'b0, 1'b0, 1'b0, 0);
        vectors++;
        if (obs_req_cycles != 4 || !obs_addr_ok || obs_early_valid != 0) begin
            miscompares++;
            $display("FAIL wait_hold: reqcyc=%0d addr_ok=%0d early_valid=%0d exp 4 1 0",
                     obs_req_cycles, obs_addr_ok, obs_early_valid);
        end
        vectors++;
        if (obs_instr !== word || obs_valid !== 1'b1 || obs_valid_after !== 1'b0) begin
            miscompares++;
            $display("FAIL wait_capture: instr=%h valid=%b/%b exp %h 1/0", obs_instr, obs_valid, obs_valid_after, word);
        end
    endtask

    task automatic test_halt();
        goto_addr(32'h8);
        step_instr(0, {OPC_SW, 26'h0}, 1'b0, 1'b0, 1'b0, 3);
        vectors++;
        if (obs_halted !== 1'b1 || obs_pc_after !== 32'hC || obs_req_after !== 1'b0 || !obs_halt_ok) begin
            miscompares++;
            $display("FAIL halt_enter: halted=%b pc=%h req=%b hold_ok=%0d exp 1 c 0 1",
                     obs_halted, obs_pc_after, obs_req_after, obs_halt_ok);
        end
        vectors++;
        if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'hC || halted !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_resume: req=%b addr=%h halted=%b exp 1 c 0", imem.imem_req, imem.imem_addr, halted);
        end
    endtask

    task automatic test_wrap();
        goto_addr(32'h0);
        step_instr(0, {OPC_BEQ, 10'h0, 16'hFFFE}, 1'b1, 1'b0, 1'b1, 0);
        vectors++;
        if (obs_pc_after !== 32'hFFFF_FFFC) begin
            miscompares++;
            $display("FAIL wrap_branch: next %h exp fffffffc", obs_pc_after);
        end
        step_instr(0, {OPC_RTYPE, 26'h0}, 1'b0, 1'b0, 1'b0, 0);
        vectors++;
        if (obs_plus4 !== 32'h0 || obs_pc_after !== 32'h0) begin
            miscompares++;
            $display("FAIL wrap_incr: plus4 %h next %h exp 0 0", obs_plus4, obs_pc_after);
        end
    endtask

    task automatic test_random();
        logic [5:0] opcs [5];
        logic [31:0] word;
        int waits, hc;
        opcs[0] = OPC_RTYPE; opcs[1] = OPC_LW; opcs[2] = OPC_SW; opcs[3] = OPC_BEQ; opcs[4] = OPC_J;
        for (int n = 0; n < 60; n++) begin
            word  = {opcs[$urandom_range(0, 4)], 26'($urandom())};
            waits = $urandom_range(0, 4);
            hc    = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0;
            step_instr(waits, word, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), hc);
            vectors++;
            if (!obs_addr_ok || obs_req_cycles != waits + 1 || obs_early_valid != 0 ||
                obs_valid !== 1'b1 || obs_instr !== word || obs_valid_after !== 1'b0) begin
                miscompares++;
                $display("FAIL rand_fetch%0d: addr_ok=%0d reqcyc=%0d/%0d ev=%0d valid=%b instr=%h exp %h",
                         n, obs_addr_ok, obs_req_cycles, waits + 1, obs_early_valid, obs_valid, obs_instr, word);
            end
            vectors++;
            if (obs_pc_after !== m_pc || obs_plus4 !== exp_plus4 || obs_count_after !== m_count) begin
                miscompares++;
                $display("FAIL rand_pc%0d: next %h plus4 %h cnt %0d exp %h %h %0d",
                         n, obs_pc_after, obs_plus4, obs_count_after, m_pc, exp_plus4, m_count);
            end
            vectors++;
            if (obs_halted !== (hc > 0) || obs_req_after !== (hc == 0) || !obs_halt_ok) begin
                miscompares++;
                $display("FAIL rand_halt%0d: halted=%b req=%b hold_ok=%0d exp halted=%0d",
                         n, obs_halted, obs_req_after, obs_halt_ok, hc > 0);
            end
        end
    endtask

    task automatic test_timeout();
        int guard;
        guard = 0;
        while (!imem.imem_req && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        for (int c = 0; c < int'(TMO) + 5; c++) begin
            vectors++;
            if (fetch_error !== (c >= int'(TMO)) || imem.imem_req !== (c < int'(TMO)) || pc !== m_pc) begin
                miscompares++;
                $display("FAIL timeout_c%0d: err=%b req=%b pc=%h exp err=%0d req=%0d pc=%h",
                         c, fetch_error, imem.imem_req, pc, c >= int'(TMO), c < int'(TMO), m_pc);
            end
            imem.imem_ready = (c >= int'(TMO)) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
        end
        imem.imem_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_pc = 32'h0; m_count = 32'h0;
        goto_addr(32'h40);
        imem.imem_ready = 1'b0;
        @(negedge clk);
        imem.imem_ready = 1'b1;
        imem.imem_rdata = 32'hDEAD_BEEF;
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({imem.imem_req, instr_valid, halted, fetch_error} !== 4'b0 || pc !== 32'h0 ||
            instruction !== 32'h0 || instr_count !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mid: req/valid/halt/err=%b pc=%h instr=%h cnt=%0d exp all zero",
                     {imem.imem_req, instr_valid, halted, fetch_error}, pc, instruction, instr_count);
        end
        @(negedge clk);
        imem.imem_ready = 1'b0;
        rst_n = 1'b1;
        m_pc = 32'h0; m_count = 32'h0;
        step_instr(0, {OPC_RTYPE, 26'h0}, 1'b0, 1'b0, 1'b0, 0);
        vectors++;
        if (!obs_addr_ok || obs_pc_issue !== 32'h0 || obs_pc_after !== 32'h4 || obs_count_after !== 32'd1) begin
            miscompares++;
            $display("FAIL reset_mid_restart: addr_ok=%0d pc=%h next=%h cnt=%0d exp 1 0 4 1",
                     obs_addr_ok, obs_pc_issue, obs_pc_after, obs_count_after);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        branch_select = 1'b0; jump_select = 1'b0; alu_zero = 1'b0; halt_req = 1'b0;
        imem.imem_ready = 1'b0; imem.imem_rdata = 32'h0;
        m_pc = 32'h0; m_count = 32'h0;
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_wait();
        test_halt();
        test_wrap();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Instruction-fetch stage directly upstream of the control decoder.
- Holds the program counter and issues word reads to instruction memory through a req/ready handshake.
- Presents each fetched 32-bit instruction to the decoder for exactly one cycle.
- Selects the next PC from the decoder's branch_select and jump_select flags plus the ALU zero result.
- Supports a halt request, an instruction-memory timeout error, and an issued-instruction counter.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; must be word aligned.
TIMEOUT_CYCLES, 16, maximum cycles spent in FETCH waiting for imem_ready before ERROR; legal range 2..255.

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  read request; held high throughout FETCH
imem_addr  out  32  read address; equals pc while imem_req is high
imem_rdata  in  32  instruction word; sampled only when imem_req && imem_ready
imem_ready  in  1  memory completion strobe
branch_select  in  1  decoder flag: beq
jump_select  in  1  decoder flag: j
alu_zero  in  1  ALU equality result for the current instruction
halt_req  in  1  pause request, level-sensitive
instruction  out  32  latched instruction word, stable through ISSUE
instr_valid  out  1  high for exactly one cycle per instruction, in ISSUE
pc  out  32  address of the current instruction
pc_plus4  out  32  pc + 4, modulo 2^32
halted  out  1  high in HALTED
fetch_error  out  1  high in ERROR
instr_count  out  32  number of ISSUE cycles since reset; wraps

Behaviour:
- Reset, asynchronous on rst_n low, from any state including mid-handshake:
  - pc=RESET_PC, state=FETCH, instruction=0, instr_count=0, timeout counter=0.
  - All 1-bit outputs are 0 while rst_n is low.
  - imem_req rises in the first cycle after rst_n deasserts.
- FSM states: FETCH, ISSUE, HALTED, ERROR.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - imem_ready=1: latch imem_rdata into instruction, clear the timeout counter, go to ISSUE. Zero-wait memory (ready in the same cycle as req) is legal.
  - imem_ready=0: increment the timeout counter. If the counter equals TIMEOUT_CYCLES-1, go to ERROR. fetch_error is therefore first high TIMEOUT_CYCLES cycles after FETCH entry.
- ISSUE (exactly one cycle):
  - instr_valid=1; increment instr_count.
  - At the clock edge, pc takes next_pc.
  - halt_req=1: go to HALTED; otherwise go to FETCH.
  - Minimum throughput is 2 cycles per instruction.
- next_pc, evaluated only in ISSUE, in priority order:
  - jump_select=1: {pc_plus4[31:28], instruction[25:0], 2'b00}.
  - branch_select=1 && alu_zero=1: pc_plus4 + (sign_extend(instruction[15:0]) << 2), modulo 2^32.
  - Otherwise: pc_plus4.
  - jump_select takes priority if both flags are high.
  - pc[1:0] is always 00.
- HALTED:
  - imem_req=0, halted=1; pc holds the already-updated next address.
  - halt_req=0: return to FETCH.
  - halt_req asserted outside ISSUE is not acted on until the next ISSUE.
- ERROR:
  - Terminal until reset; fetch_error=1, imem_req=0, pc frozen at the failing address.
- imem_ready outside FETCH is ignored.
- instruction holds its last value outside FETCH-capture.
- branch_select, jump_select and alu_zero are don't-care outside ISSUE.
- PC increment and branch arithmetic wrap silently at 32 bits, e.g. pc 0xFFFF_FFFC → 0x0000_0000.

Decomposition:
- Package pc_fetch_pkg:
  - state enum {FETCH, ISSUE, HALTED, ERROR};
  - constants OPC_RTYPE=6'b000000, OPC_LW=6'b100011, OPC_SW=6'b101011, OPC_BEQ=6'b000100, OPC_J=6'b000010 (bench use);
  - function sign_extend16.
- Sub-module next_pc_calc: purely combinational.
  - Inputs: pc, instruction, branch_select, jump_select, alu_zero.
  - Outputs: next_pc, pc_plus4.
- The FSM, PC register, timeout counter and instr_count stay in the top module.

Test Plan:
- Sequential fetch, zero-wait memory, no branches, 3 instructions → imem_addr 0x0, 0x4, 0x8; instr_valid every other cycle; instr_count=3.
- Taken beq at pc 0x10, imm16=0xFFFC, alu_zero=1 → next imem_addr 0x4. Same with alu_zero=0 → next imem_addr 0x14.
- j at pc 0x20 with instruction[25:0]=26'h40 → next imem_addr 0x100. j with branch_select also high → still 0x100.
- imem_ready delayed 3 cycles → imem_req/imem_addr held stable 4 cycles, instruction captured once, one instr_valid pulse. imem_ready never asserted, TIMEOUT_CYCLES=16 → fetch_error=1 sixteen cycles after FETCH entry, imem_req=0 thereafter, pc unchanged.
- halt_req=1 during ISSUE at pc 0x8 → halted=1, pc=0xC, no imem_req. Drop halt_req → FETCH at 0xC next cycle.
- rst_n low mid-FETCH at pc 0x40 with ready pending → outputs immediately 0, pc=RESET_PC. After release, first imem_addr=0x0.
